// File: rtl/ex_stage_if.sv
// Bus between the decode/hazard logic and the execute stage: decoded
// instruction fields, stall/flush controls, EX-stage hazard outputs and the
// registered EX/MEM results.
interface ex_stage_if #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
);
    // Hazard-unit controls
    logic               stall_e;
    logic               flush_e;

    // Decode-stage instruction
    logic               valid_d;
    logic               regwrite_d;
    logic               memtoreg_d;
    logic               memwrite_d;
    logic               alusrc_d;
    logic               regdst_d;
    logic [2:0]         alucontrol_d;
    logic [WIDTH-1:0]   rd1_d;
    logic [WIDTH-1:0]   rd2_d;
    logic [WIDTH-1:0]   signimm_d;
    logic [REGBITS-1:0] rt_d;
    logic [REGBITS-1:0] rd_d;

    // EX-stage hazard signals
    logic               regwrite_e;
    logic               memtoreg_e;
    logic [REGBITS-1:0] writereg_e;

    // EX/MEM register outputs
    logic               valid_m;
    logic               regwrite_m;
    logic               memtoreg_m;
    logic               memwrite_m;
    logic [WIDTH-1:0]   aluout_m;
    logic [WIDTH-1:0]   writedata_m;
    logic [REGBITS-1:0] writereg_m;
    logic               zero_m;
    logic               aluerr_m;

    // Decode side: drives the instruction, observes the stage outputs
    modport master (
        output stall_e, flush_e,
        output valid_d, regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d,
        output alucontrol_d, rd1_d, rd2_d, signimm_d, rt_d, rd_d,
        input  regwrite_e, memtoreg_e, writereg_e,
        input  valid_m, regwrite_m, memtoreg_m, memwrite_m,
        input  aluout_m, writedata_m, writereg_m, zero_m, aluerr_m
    );

    // Execute stage
    modport slave (
        input  stall_e, flush_e,
        input  valid_d, regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d,
        input  alucontrol_d, rd1_d, rd2_d, signimm_d, rt_d, rd_d,
        output regwrite_e, memtoreg_e, writereg_e,
        output valid_m, regwrite_m, memtoreg_m, memwrite_m,
        output aluout_m, writedata_m, writereg_m, zero_m, aluerr_m
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the pipelined MIPS core: ID/EX register, 32-bit ALU,
// destination-register select and EX/MEM register, with stall/flush support.
module ex_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    ex_stage_if.slave   bus
);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regdst;
        logic [2:0]         alucontrol;
        logic [WIDTH-1:0]   rd1;
        logic [WIDTH-1:0]   rd2;
        logic [WIDTH-1:0]   signimm;
        logic [REGBITS-1:0] rt;
        logic [REGBITS-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic [WIDTH-1:0]   aluout;
        logic [WIDTH-1:0]   writedata;
        logic [REGBITS-1:0] writereg;
        logic               zero;
        logic               aluerr;
    } exmem_t;

    // An ID/EX bubble is all zero except the ALU code, which idles at add.
    function automatic idex_t idex_bubble();
        idex_t b;
        b            = '0;
        b.alucontrol = ALU_ADD;
        return b;
    endfunction

    idex_t              idex_d;
    idex_t              idex_q;
    exmem_t             exmem_d;
    exmem_t             exmem_q;
    logic [WIDTH-1:0]   src_b;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_err;
    logic [REGBITS-1:0] writereg;

    // Gather the decode-stage fields into one ID/EX word
    always_comb begin
        idex_d.valid      = bus.valid_d;
        idex_d.regwrite   = bus.regwrite_d;
        idex_d.memtoreg   = bus.memtoreg_d;
        idex_d.memwrite   = bus.memwrite_d;
        idex_d.alusrc     = bus.alusrc_d;
        idex_d.regdst     = bus.regdst_d;
        idex_d.alucontrol = bus.alucontrol_d;
        idex_d.rd1        = bus.rd1_d;
        idex_d.rd2        = bus.rd2_d;
        idex_d.signimm    = bus.signimm_d;
        idex_d.rt         = bus.rt_d;
        idex_d.rd         = bus.rd_d;
    end

    // ID/EX register: flush wins over stall, stall holds the current entry
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= idex_bubble();
        end else if (bus.flush_e) begin
            idex_q <= idex_bubble();
        end else if (!bus.stall_e) begin
            idex_q <= idex_d;
        end
    end

    // ALU: unsupported codes yield 0 and flag an error for real instructions
    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        alu_result = '0;
        alu_err    = 1'b0;
        src_b      = idex_q.alusrc ? idex_q.signimm : idex_q.rd2;
        case (idex_q.alucontrol)
            ALU_ADD: alu_result = idex_q.rd1 + src_b;
            ALU_SUB: alu_result = idex_q.rd1 - src_b;
            ALU_AND: alu_result = idex_q.rd1 & src_b;
            ALU_OR:  alu_result = idex_q.rd1 | src_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}},
                                   ($signed(idex_q.rd1) < $signed(src_b))};
            default: alu_err    = idex_q.valid;
        endcase
    end

    // Destination select: rd for R-type, rt otherwise
    always_comb begin
        writereg = idex_q.regdst ? idex_q.rd : idex_q.rt;
    end

    // Next EX/MEM word; a bubble carries no write enables and no flags
    always_comb begin
        exmem_d.valid     = idex_q.valid;
        exmem_d.regwrite  = idex_q.valid & idex_q.regwrite;
        exmem_d.memtoreg  = idex_q.valid & idex_q.memtoreg;
        exmem_d.memwrite  = idex_q.valid & idex_q.memwrite;
        exmem_d.aluout    = alu_result;
        exmem_d.writedata = idex_q.rd2;
        exmem_d.writereg  = writereg;
        exmem_d.zero      = idex_q.valid & (alu_result == '0);
        exmem_d.aluerr    = alu_err;
    end

    // EX/MEM register: a stall sends a bubble so the held instruction issues once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_q <= '0;
        end else if (bus.stall_e) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    // EX-stage hazard outputs come only from the ID/EX register
    assign bus.regwrite_e  = idex_q.regwrite;
    assign bus.memtoreg_e  = idex_q.memtoreg;
    assign bus.writereg_e  = writereg;

    assign bus.valid_m     = exmem_q.valid;
    assign bus.regwrite_m  = exmem_q.regwrite;
    assign bus.memtoreg_m  = exmem_q.memtoreg;
    assign bus.memwrite_m  = exmem_q.memwrite;
    assign bus.aluout_m    = exmem_q.aluout;
    assign bus.writedata_m = exmem_q.writedata;
    assign bus.writereg_m  = exmem_q.writereg;
    assign bus.zero_m      = exmem_q.zero;
    assign bus.aluerr_m    = exmem_q.aluerr;

endmodule
